writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk_i is the single clock; rst_i is asynchronous and active-high.
REQ-002 SHALL have the following ports:
- clk_i  in  1  clock.
- rst_i  in  1  async active-high reset.
- stall_i  in  1  global pipeline stall.
- valid_i  in  1  instruction in WB is valid.
- rd_data_i  in  64  non-load result.
- rd_idx_i  in  5  destination register.
- rd_wr_en_i  in  1  instruction writes rd.
- rd_wr_src_1h_i  in  3  source select: 001 ALU/rd_data, 010 load data, 100 rd_data (CSR/link).
- mem_width_1h_i  in  4  0001 byte, 0010 half, 0100 word, 1000 double.
- mem_sign_i  in  1  sign-extend load.
- byte_addr_i  in  3  load byte offset within the 64-bit line.
- dmem_rdata_i  in  64  data memory read data.
- dmem_rvalid_i  in  1  read data valid.
- rf_wr_en_o  out  1  register file write strobe (combinational).
- rf_wr_idx_o  out  5  write index (= rd_idx_i).
- rf_wr_data_o  out  64  write data (combinational).
- load_stall_ao  out  1  load in WB still awaiting data.
- retire_o  out  1  registered one-cycle retire pulse.
- instret_o  out  64  retired-instruction counter.
- dmem_err_o  out  1  sticky protocol-error flag.

Function
REQ-003 SHALL define is_load = rd_wr_src_1h_i == 010, and load_pending = valid_i & is_load.
REQ-004 SHALL define data_avail = dmem_rvalid_i | held_q, where held_q is the rdata hold-buffer valid bit.
REQ-005 SHALL drive load_stall_ao = load_pending & ~data_avail, with no combinational path from stall_i.
REQ-006 SHALL define commit = valid_i & ~stall_i & (~is_load | data_avail).
REQ-007 SHALL drive rf_wr_en_o = commit & rd_wr_en_i & (rd_idx_i != 0); writes to x0 are suppressed.
REQ-008 SHALL select the load source word as held_q ? rdata_q : dmem_rdata_i, with the held copy taking priority.
REQ-009 SHALL extract load data by right-shifting the source word by byte_addr_i*8 and keeping the low 8/16/32/64 bits per mem_width_1h_i.
REQ-010 SHALL sign-extend the extracted load data to 64 bits when mem_sign_i=1 and zero-extend it otherwise; DOUBLE ignores mem_sign_i.
REQ-011 SHALL produce a load result of 0 when mem_width_1h_i is not one-hot.
REQ-012 SHALL drive rf_wr_data_o = load result when is_load and rd_data_i otherwise, including for an unrecognised source select.
REQ-013 SHALL implement a hold-buffer FSM with states EMPTY (held_q=0) and HELD (held_q=1), with the following transitions:
- EMPTY->HELD: when load_pending & dmem_rvalid_i & ~commit; captures rdata_q <= dmem_rdata_i.
- HELD->EMPTY: on commit.
- EMPTY, rvalid & commit in the same cycle: data is consumed directly and the FSM stays EMPTY.
REQ-014 SHALL set dmem_err_o and keep it set until reset when dmem_rvalid_i=1 while no load is pending or held_q=1; the buffer is not overwritten.
REQ-015 SHALL register retire_o <= commit.
REQ-016 SHALL increment instret_o by 1 per commit, including stores, branches and x0 writes, and SHALL wrap from 2^64-1 to 0.
REQ-017 SHALL hold all state unchanged while stall_i=1, except hold-buffer capture and error detection.
REQ-018 SHALL apply these edge cases:
- valid_i=0: rf_wr_en_o=0 and load_stall_ao=0.
- A held entry persists across any number of stall cycles.

Reset
REQ-019 SHALL, on rst_i assertion, asynchronously clear held_q, rdata_q, retire_o, instret_o and dmem_err_o to 0.
REQ-020 SHALL discard a pending or held load when reset is asserted mid-operation; no RF write occurs for it after reset release.
REQ-021 SHALL keep combinational outputs a function of inputs and cleared state during reset.

Verification
REQ-022 SHALL be verified by a bench covering these scenarios:
- ALU op: valid, src=001, rd=5, data=0x1234, no stall -> rf_wr_en_o=1, idx 5, data 0x1234; next cycle retire_o=1, instret_o=1.
- LB signed: byte_addr=3, rdata=0x00000000_80000000 with rvalid same cycle -> rf_wr_data_o=0xFFFFFFFF_FFFFFF80. LWU on the same data at byte_addr=4 -> 0x0000_0000_0000_0000.
- Delayed load: load valid with rvalid low for 3 cycles -> load_stall_ao=1 and rf_wr_en_o=0 for those 3 cycles; when rvalid rises -> commit in the same cycle.
- Hold buffer: rvalid arrives with stall_i=1 (rdata=0xDEAD_BEEF), stall held 2 more cycles, dmem_rdata_i changed to 0 -> on release, LW unsigned writes 0xDEADBEEF; afterwards held_q=0.
- Error and edge cases: rvalid with valid_i=0 -> dmem_err_o=1, staying set until rst_i. Write to x0 -> rf_wr_en_o=0, instret_o still increments. instret_o preloaded to 2^64-1 via commits -> wraps to 0.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: selects and formats the register-file write data, holds
// early-arriving load data across stalls, and counts retired instructions.
//
// Hold-buffer FSM
//   state    | meaning
//   ST_EMPTY | no load data buffered; loads take dmem_rdata_i directly
//   ST_HELD  | load data captured in r_rdata, waiting for the load to commit
module writeback_stage #(
    // Reset value of the retire counter. Leave at zero in normal use; a
    // nonzero value only shortens the time needed to reach the wrap point.
    parameter logic [63:0] INSTRET_RST = 64'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        valid_i,
    input  logic [63:0] rd_data_i,
    input  logic [4:0]  rd_idx_i,
    input  logic        rd_wr_en_i,
    input  logic [2:0]  rd_wr_src_1h_i,
    input  logic [3:0]  mem_width_1h_i,
    input  logic        mem_sign_i,
    input  logic [2:0]  byte_addr_i,
    input  logic [63:0] dmem_rdata_i,
    input  logic        dmem_rvalid_i,
    output logic        rf_wr_en_o,
    output logic [4:0]  rf_wr_idx_o,
    output logic [63:0] rf_wr_data_o,
    output logic        load_stall_ao,
    output logic        retire_o,
    output logic [63:0] instret_o,
    output logic        dmem_err_o
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_HELD  = 1'b1;

    logic        r_state;
    logic [63:0] r_rdata;
    logic        r_retire;
    logic [63:0] r_instret;
    logic        r_err;

    logic        w_is_load;
    logic        w_held;
    logic        w_load_pending;
    logic        w_data_avail;
    logic        w_commit;
    logic        w_err_evt;
    logic [63:0] w_src_word;
    logic [63:0] w_shifted;
    logic [63:0] w_load_result;

    assign w_is_load      = (rd_wr_src_1h_i == 3'b010);
    assign w_held         = (r_state == ST_HELD);
    assign w_load_pending = valid_i & w_is_load;
    assign w_data_avail   = dmem_rvalid_i | w_held;
    assign w_commit       = valid_i & ~stall_i & (~w_is_load | w_data_avail);

    // Data arriving with nothing to consume it, or on top of a held copy,
    // is a protocol violation; the held copy is never overwritten.
    assign w_err_evt      = dmem_rvalid_i & (~w_load_pending | w_held);

    assign w_src_word     = w_held ? r_rdata : dmem_rdata_i;
    assign w_shifted      = w_src_word >> {byte_addr_i, 3'b000};

    // Width selection and sign/zero extension of the shifted load word
    always_comb begin
        w_load_result = 64'd0;
        case (mem_width_1h_i)
            4'b0001: w_load_result = mem_sign_i ? {{56{w_shifted[7]}},  w_shifted[7:0]}
                                                : {56'd0, w_shifted[7:0]};
            4'b0010: w_load_result = mem_sign_i ? {{48{w_shifted[15]}}, w_shifted[15:0]}
                                                : {48'd0, w_shifted[15:0]};
            4'b0100: w_load_result = mem_sign_i ? {{32{w_shifted[31]}}, w_shifted[31:0]}
                                                : {32'd0, w_shifted[31:0]};
            4'b1000: w_load_result = w_shifted;
            default: w_load_result = 64'd0;
        endcase
    end

    assign rf_wr_en_o    = w_commit & rd_wr_en_i & (rd_idx_i != 5'd0);
    assign rf_wr_idx_o   = rd_idx_i;
    assign rf_wr_data_o  = w_is_load ? w_load_result : rd_data_i;
    assign load_stall_ao = w_load_pending & ~w_data_avail;
    assign retire_o      = r_retire;
    assign instret_o     = r_instret;
    assign dmem_err_o    = r_err;

    // Hold-buffer FSM: capture load data that arrives while WB cannot commit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_EMPTY;
            r_rdata <= 64'd0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_load_pending & dmem_rvalid_i & ~w_commit) begin
                        r_state <= ST_HELD;
                        r_rdata <= dmem_rdata_i;
                    end
                end
                ST_HELD: begin
                    if (w_commit) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    // Retire pulse and wrapping retired-instruction counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_retire  <= 1'b0;
            r_instret <= INSTRET_RST;
        end else begin
            r_retire <= w_commit;
            if (w_commit) begin
                r_instret <= r_instret + 64'd1;
            end
        end
    end

    // Sticky protocol-error flag, cleared only by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: the stimulus process pushes expected
// register-file writes, the monitor pops and compares on every rf_wr_en_o.
module tb_writeback_stage;

    typedef struct packed {
        logic [4:0]  idx;
        logic [63:0] data;
    } wr_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i, valid_i, rd_wr_en_i, mem_sign_i, dmem_rvalid_i;
    logic [63:0] rd_data_i, dmem_rdata_i;
    logic [4:0]  rd_idx_i;
    logic [2:0]  rd_wr_src_1h_i, byte_addr_i;
    logic [3:0]  mem_width_1h_i;

    logic        rf_wr_en_o, load_stall_ao, retire_o, dmem_err_o;
    logic [4:0]  rf_wr_idx_o;
    logic [63:0] rf_wr_data_o, instret_o;

    logic        w_wr_en, w_lstall, w_retire, w_err;
    logic [4:0]  w_idx;
    logic [63:0] w_data, w_instret;

    int  errors = 0;
    int  checks = 0;
    wr_t exp_q[$];
    logic [63:0] exp_instret;

    always #5 clk_i = ~clk_i;

    writeback_stage u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .valid_i(valid_i),
        .rd_data_i(rd_data_i), .rd_idx_i(rd_idx_i), .rd_wr_en_i(rd_wr_en_i),
        .rd_wr_src_1h_i(rd_wr_src_1h_i), .mem_width_1h_i(mem_width_1h_i),
        .mem_sign_i(mem_sign_i), .byte_addr_i(byte_addr_i),
        .dmem_rdata_i(dmem_rdata_i), .dmem_rvalid_i(dmem_rvalid_i),
        .rf_wr_en_o(rf_wr_en_o), .rf_wr_idx_o(rf_wr_idx_o),
        .rf_wr_data_o(rf_wr_data_o), .load_stall_ao(load_stall_ao),
        .retire_o(retire_o), .instret_o(instret_o), .dmem_err_o(dmem_err_o)
    );

    // Second instance starting just below the wrap point
    writeback_stage #(.INSTRET_RST(64'hFFFF_FFFF_FFFF_FFFE)) u_wrap (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .valid_i(valid_i),
        .rd_data_i(rd_data_i), .rd_idx_i(rd_idx_i), .rd_wr_en_i(rd_wr_en_i),
        .rd_wr_src_1h_i(rd_wr_src_1h_i), .mem_width_1h_i(mem_width_1h_i),
        .mem_sign_i(mem_sign_i), .byte_addr_i(byte_addr_i),
        .dmem_rdata_i(dmem_rdata_i), .dmem_rvalid_i(dmem_rvalid_i),
        .rf_wr_en_o(w_wr_en), .rf_wr_idx_o(w_idx),
        .rf_wr_data_o(w_data), .load_stall_ao(w_lstall),
        .retire_o(w_retire), .instret_o(w_instret), .dmem_err_o(w_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Monitor: every presented RF write must match the oldest expected entry
    always @(negedge clk_i) begin
        if (rf_wr_en_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wr: got idx %0d data 0x%016h expected no write",
                         rf_wr_idx_o, rf_wr_data_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (rf_wr_idx_o !== e.idx || rf_wr_data_o !== e.data) begin
                    errors++;
                    $display("FAIL rf_wr: got idx %0d data 0x%016h expected idx %0d data 0x%016h",
                             rf_wr_idx_o, rf_wr_data_o, e.idx, e.data);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic st, input logic [2:0] src,
                         input logic [4:0] rd, input logic we, input logic [63:0] d,
                         input logic [3:0] w, input logic sg, input logic [2:0] ba,
                         input logic [63:0] rdat, input logic rv);
        valid_i = v;  stall_i = st;  rd_wr_src_1h_i = src;  rd_idx_i = rd;
        rd_wr_en_i = we;  rd_data_i = d;  mem_width_1h_i = w;  mem_sign_i = sg;
        byte_addr_i = ba;  dmem_rdata_i = rdat;  dmem_rvalid_i = rv;
    endtask

    task automatic expect_wr(input logic [4:0] idx, input logic [63:0] data);
        wr_t e;
        e.idx = idx;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b001, 5'd0, 1'b0, 64'd0, 4'b1000, 1'b0, 3'd0, 64'd0, 1'b0);
    endtask

    initial begin
        idle();
        exp_instret = 64'd0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_retire", {63'd0, retire_o}, 64'd0);
        chk("rst_instret", instret_o, 64'd0);
        chk("rst_err", {63'd0, dmem_err_o}, 64'd0);
        chk("rst_lstall", {63'd0, load_stall_ao}, 64'd0);
        rst_i = 1'b0;

        // ALU op
        next_cycle();
        drive(1, 0, 3'b001, 5'd5, 1, 64'h1234, 4'b1000, 0, 3'd0, 64'd0, 0);
        expect_wr(5'd5, 64'h1234); exp_instret++;
        @(negedge clk_i);

        // LB signed, byte 3
        next_cycle();
        drive(1, 0, 3'b010, 5'd6, 1, 64'd0, 4'b0001, 1, 3'd3, 64'h0000_0000_8000_0000, 1);
        expect_wr(5'd6, 64'hFFFF_FFFF_FFFF_FF80);
        @(negedge clk_i);
        chk("alu_retire", {63'd0, retire_o}, 64'd1);
        chk("alu_instret", instret_o, exp_instret);
        chk("wrap_max", w_instret, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("lb_lstall", {63'd0, load_stall_ao}, 64'd0);
        exp_instret++;

        // LWU, byte 4
        next_cycle();
        drive(1, 0, 3'b010, 5'd7, 1, 64'd0, 4'b0100, 0, 3'd4, 64'h0000_0000_8000_0000, 1);
        expect_wr(5'd7, 64'd0);
        @(negedge clk_i);
        chk("wrap_zero", w_instret, 64'd0);
        exp_instret++;

        // Delayed load: three cycles without data
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive(1, 0, 3'b010, 5'd8, 1, 64'd0, 4'b1000, 0, 3'd0, 64'hFFFF_0000_FFFF_0000, 0);
            @(negedge clk_i);
            chk("delay_lstall", {63'd0, load_stall_ao}, 64'd1);
        end
        chk("delay_instret", instret_o, exp_instret);
        next_cycle();
        drive(1, 0, 3'b010, 5'd8, 1, 64'd0, 4'b1000, 0, 3'd0, 64'h0123_4567_89AB_CDEF, 1);
        expect_wr(5'd8, 64'h0123_4567_89AB_CDEF); exp_instret++;
        @(negedge clk_i);
        chk("delay_done_lstall", {63'd0, load_stall_ao}, 64'd0);

        // Hold buffer: data arrives under stall, stall lasts 2 more cycles
        next_cycle();
        drive(1, 1, 3'b010, 5'd9, 1, 64'd0, 4'b0100, 0, 3'd0, 64'h0000_0000_DEAD_BEEF, 1);
        @(negedge clk_i);
        chk("hold_cap_lstall", {63'd0, load_stall_ao}, 64'd0);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            drive(1, 1, 3'b010, 5'd9, 1, 64'd0, 4'b0100, 0, 3'd0, 64'd0, 0);
            @(negedge clk_i);
            chk("hold_stall_lstall", {63'd0, load_stall_ao}, 64'd0);
            chk("hold_stall_retire", {63'd0, retire_o}, 64'd0);
        end
        chk("hold_instret", instret_o, exp_instret);
        next_cycle();
        drive(1, 0, 3'b010, 5'd9, 1, 64'd0, 4'b0100, 0, 3'd0, 64'd0, 0);
        expect_wr(5'd9, 64'h0000_0000_DEAD_BEEF); exp_instret++;
        @(negedge clk_i);
        // Buffer must be empty again: a new load without data stalls
        next_cycle();
        drive(1, 0, 3'b010, 5'd10, 1, 64'd0, 4'b0010, 1, 3'd0, 64'd0, 0);
        @(negedge clk_i);
        chk("hold_cleared_lstall", {63'd0, load_stall_ao}, 64'd1);
        next_cycle();
        drive(1, 0, 3'b010, 5'd10, 1, 64'd0, 4'b0010, 1, 3'd0, 64'h0000_0000_0000_8001, 1);
        expect_wr(5'd10, 64'hFFFF_FFFF_FFFF_8001); exp_instret++;
        @(negedge clk_i);

        // x0 write: no RF write, still retires
        next_cycle();
        drive(1, 0, 3'b001, 5'd0, 1, 64'h55, 4'b1000, 0, 3'd0, 64'd0, 0);
        exp_instret++;
        @(negedge clk_i);
        // Store (no rd write)
        next_cycle();
        drive(1, 0, 3'b001, 5'd3, 0, 64'h66, 4'b1000, 0, 3'd0, 64'd0, 0);
        exp_instret++;
        @(negedge clk_i);
        chk("x0_retire", {63'd0, retire_o}, 64'd1);
        // CSR/link source
        next_cycle();
        drive(1, 0, 3'b100, 5'd11, 1, 64'hABC, 4'b1000, 0, 3'd0, 64'd0, 0);
        expect_wr(5'd11, 64'hABC); exp_instret++;
        @(negedge clk_i);
        // Unrecognised source select falls back to rd_data
        next_cycle();
        drive(1, 0, 3'b011, 5'd12, 1, 64'h777, 4'b1000, 0, 3'd0, 64'd0, 0);
        expect_wr(5'd12, 64'h777); exp_instret++;
        @(negedge clk_i);
        // Load with non-one-hot width gives 0
        next_cycle();
        drive(1, 0, 3'b010, 5'd13, 1, 64'd0, 4'b0011, 1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        expect_wr(5'd13, 64'd0); exp_instret++;
        @(negedge clk_i);
        // Stalled ALU op: nothing happens
        next_cycle();
        drive(1, 1, 3'b001, 5'd14, 1, 64'h999, 4'b1000, 0, 3'd0, 64'd0, 0);
        @(negedge clk_i);
        next_cycle();
        idle();
        @(negedge clk_i);
        chk("stall_retire", {63'd0, retire_o}, 64'd0);
        chk("edge_instret", instret_o, exp_instret);
        chk("edge_err", {63'd0, dmem_err_o}, 64'd0);

        // Reset while a load is held: the held data is discarded
        next_cycle();
        drive(1, 1, 3'b010, 5'd15, 1, 64'd0, 4'b1000, 0, 3'd0, 64'h1111, 1);
        @(negedge clk_i);
        next_cycle();
        drive(1, 1, 3'b010, 5'd15, 1, 64'd0, 4'b1000, 0, 3'd0, 64'h1111, 0);
        rst_i = 1'b1;
        #2;
        rst_i = 1'b0;
        exp_instret = 64'd0;
        @(negedge clk_i);
        drive(1, 0, 3'b010, 5'd15, 1, 64'd0, 4'b1000, 0, 3'd0, 64'h1111, 0);
        #1;
        chk("midrst_lstall", {63'd0, load_stall_ao}, 64'd1);
        chk("midrst_instret", instret_o, 64'd0);
        next_cycle();
        idle();
        @(negedge clk_i);

        // Data valid with no instruction: sticky error
        next_cycle();
        drive(0, 0, 3'b001, 5'd0, 0, 64'd0, 4'b1000, 0, 3'd0, 64'h42, 1);
        @(negedge clk_i);
        next_cycle();
        idle();
        @(negedge clk_i);
        chk("err_set", {63'd0, dmem_err_o}, 64'd1);
        repeat (3) begin
            next_cycle();
            @(negedge clk_i);
        end
        chk("err_sticky", {63'd0, dmem_err_o}, 64'd1);
        rst_i = 1'b1;
        #1;
        chk("err_rst", {63'd0, dmem_err_o}, 64'd0);
        chk("err_rst_instret", instret_o, 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_wr: got %0d writes outstanding expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
